// File: rtl/traffic_ctrl_timed.sv
// Two-road intersection controller: timed Moore FSM with a demand-driven side-road
// green, pedestrian walk service and a blinking flash (fault/night) mode.
module traffic_ctrl_timed #(
    parameter int CNT_W    = 8,
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 4,
    parameter int T_ALLRED = 2,
    parameter int T_WALK   = 10,
    parameter int T_FLASH  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       flash,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [2:0] S_MAIN_G = 3'd0;
    localparam logic [2:0] S_MAIN_Y = 3'd1;
    localparam logic [2:0] S_AR1    = 3'd2;
    localparam logic [2:0] S_SIDE_G = 3'd3;
    localparam logic [2:0] S_SIDE_Y = 3'd4;
    localparam logic [2:0] S_AR2    = 3'd5;
    localparam logic [2:0] S_FLASH  = 3'd6;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Timers hold T-1 on entry and count down to zero, so each phase lasts T cycles.
    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(T_FLASH - 1);
    // Walk lamp is lit while the SIDE_G timer is still at or above this value.
    localparam logic [CNT_W-1:0] WALK_THR  = CNT_W'(T_GREEN - T_WALK);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q,     state_d;
    logic [CNT_W-1:0] timer_q,     timer_d;
    logic             ped_pend_q,  ped_pend_d;
    logic             walk_en_q,   walk_en_d;
    logic             blink_on_q,  blink_on_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             timer_zero_s;

    assign timer_zero_s = (timer_q == CNT_ZERO);

    // Next-state logic: flash overrides everything, otherwise timed phase sequencing.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        walk_en_d   = walk_en_q;
        blink_on_d  = blink_on_q;
        blink_cnt_d = blink_cnt_q;
        // A press outside SIDE_G is remembered; a press on the cycle that enters
        // SIDE_G is folded in here and therefore served by that green.
        ped_pend_d  = ped_pend_q | (ped_req & (state_q != S_SIDE_G));

        if (flash) begin
            if (state_q != S_FLASH) begin
                state_d     = S_FLASH;
                blink_on_d  = 1'b1;
                blink_cnt_d = LD_FLASH;
            end else if (blink_cnt_q == CNT_ZERO) begin
                blink_on_d  = ~blink_on_q;
                blink_cnt_d = LD_FLASH;
            end else begin
                blink_cnt_d = blink_cnt_q - CNT_ONE;
            end
        end else begin
            case (state_q)
                S_MAIN_G: begin
                    if (!timer_zero_s) begin
                        timer_d = timer_q - CNT_ONE;
                    end else if (side_req | ped_pend_q) begin
                        state_d = S_MAIN_Y;
                        timer_d = LD_YELLOW;
                    end else begin
                        timer_d = CNT_ZERO;
                    end
                end
                S_MAIN_Y: begin
                    if (timer_zero_s) begin
                        state_d = S_AR1;
                        timer_d = LD_ALLRED;
                    end else begin
                        timer_d = timer_q - CNT_ONE;
                    end
                end
                S_AR1: begin
                    if (timer_zero_s) begin
                        state_d    = S_SIDE_G;
                        timer_d    = LD_GREEN;
                        walk_en_d  = ped_pend_d;
                        ped_pend_d = 1'b0;
                    end else begin
                        timer_d = timer_q - CNT_ONE;
                    end
                end
                S_SIDE_G: begin
                    if (timer_zero_s) begin
                        state_d = S_SIDE_Y;
                        timer_d = LD_YELLOW;
                    end else begin
                        timer_d = timer_q - CNT_ONE;
                    end
                end
                S_SIDE_Y: begin
                    if (timer_zero_s) begin
                        state_d = S_AR2;
                        timer_d = LD_ALLRED;
                    end else begin
                        timer_d = timer_q - CNT_ONE;
                    end
                end
                S_AR2: begin
                    if (timer_zero_s) begin
                        state_d = S_MAIN_G;
                        timer_d = LD_GREEN;
                    end else begin
                        timer_d = timer_q - CNT_ONE;
                    end
                end
                S_FLASH: begin
                    state_d = S_AR2;
                    timer_d = LD_ALLRED;
                end
                default: begin
                    state_d = S_AR2;
                    timer_d = LD_ALLRED;
                end
            endcase
        end
    end

    // State, timers and pedestrian bookkeeping; reset parks the junction in all-red.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_AR2;
            timer_q     <= LD_ALLRED;
            ped_pend_q  <= 1'b0;
            walk_en_q   <= 1'b0;
            blink_on_q  <= 1'b1;
            blink_cnt_q <= LD_FLASH;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ped_pend_q  <= ped_pend_d;
            walk_en_q   <= walk_en_d;
            blink_on_q  <= blink_on_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    // Lamp decode straight from registered state so reset shows all-red immediately.
    always_comb begin
        main_light = LAMP_R;
        side_light = LAMP_R;
        walk       = 1'b0;
        case (state_q)
            S_MAIN_G: begin
                main_light = LAMP_G;
                side_light = LAMP_R;
            end
            S_MAIN_Y: begin
                main_light = LAMP_Y;
                side_light = LAMP_R;
            end
            S_SIDE_G: begin
                main_light = LAMP_R;
                side_light = LAMP_G;
                walk       = walk_en_q & (timer_q >= WALK_THR);
            end
            S_SIDE_Y: begin
                main_light = LAMP_R;
                side_light = LAMP_Y;
            end
            S_FLASH: begin
                main_light = blink_on_q ? LAMP_Y : LAMP_OFF;
                side_light = blink_on_q ? LAMP_R : LAMP_OFF;
            end
            default: begin
                main_light = LAMP_R;
                side_light = LAMP_R;
            end
        endcase
    end

    assign phase = state_q;

endmodule

// File: tb/tb_traffic_ctrl_timed.sv
// Self-checking bench for traffic_ctrl_timed: directed scenarios plus random
// demand, every cycle compared against a behavioural intersection model.
module tb_traffic_ctrl_timed;

    localparam int TG = 4;
    localparam int TY = 2;
    localparam int TA = 1;
    localparam int TW = 2;
    localparam int TF = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       flash = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [2:0] phase;

    int total = 0;
    int bad = 0;

    // Model: phase number, cycles spent in it, pending press, walk granted for this green.
    int m_state;
    int m_age;
    bit m_pend;
    bit m_walk;
    int walk_seen;

    traffic_ctrl_timed #(
        .CNT_W(8), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_WALK(TW), .T_FLASH(TF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .side_req(side_req), .ped_req(ped_req), .flash(flash),
        .main_light(main_light), .side_light(side_light), .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 5;
        m_age   = 0;
        m_pend  = 1'b0;
        m_walk  = 1'b0;
    endtask

    function automatic int dur(input int s);
        case (s)
            0, 3:    return TG;
            1, 4:    return TY;
            default: return TA;
        endcase
    endfunction

    // One clock of the intersection rules, using inputs present at the edge.
    task automatic model_step();
        int nxt;
        bit newp;
        newp = m_pend || (ped_req && m_state != 3);
        nxt  = m_state;
        if (flash) begin
            nxt = 6;
        end else if (m_state == 6) begin
            nxt = 5;
        end else if (m_state == 0) begin
            if (m_age >= TG - 1 && (side_req || m_pend)) nxt = 1;
        end else if (m_age >= dur(m_state) - 1) begin
            nxt = (m_state + 1) % 6;
        end
        if (nxt != m_state) begin
            m_age = 0;
            if (nxt == 3) begin
                m_walk = newp;
                newp   = 1'b0;
            end
        end else begin
            m_age++;
        end
        m_pend  = newp;
        m_state = nxt;
    endtask

    task automatic check_outputs();
        logic [2:0] em, es;
        logic       ew, safe;
        case (m_state)
            0:       begin em = 3'b001; es = 3'b100; end
            1:       begin em = 3'b010; es = 3'b100; end
            3:       begin em = 3'b100; es = 3'b001; end
            4:       begin em = 3'b100; es = 3'b010; end
            6:       begin
                if ((m_age / TF) % 2 == 0) begin em = 3'b010; es = 3'b100; end
                else begin em = 3'b000; es = 3'b000; end
            end
            default: begin em = 3'b100; es = 3'b100; end
        endcase
        ew = (m_state == 3) && m_walk && (m_age < TW);
        chk("main_light", {5'd0, main_light}, {5'd0, em});
        chk("side_light", {5'd0, side_light}, {5'd0, es});
        chk("walk", {7'd0, walk}, {7'd0, ew});
        chk("phase", {5'd0, phase}, m_state[7:0]);
        safe = (main_light == 3'b100) || (side_light == 3'b100) || (phase == 3'd6);
        chk("safety", {7'd0, safe}, 8'd1);
        if (walk === 1'b1) walk_seen++;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int st, input int maxc, input string tag);
        int c;
        c = 0;
        while (m_state != st && c < maxc) begin
            step();
            c++;
        end
        chk(tag, m_state[7:0], st[7:0]);
    endtask

    initial begin
        model_reset();
        walk_seen = 0;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_main", {5'd0, main_light}, 8'h04);
        chk("rst_side", {5'd0, side_light}, 8'h04);
        chk("rst_walk", {7'd0, walk}, 8'd0);
        chk("rst_phase", {5'd0, phase}, 8'd5);
        @(negedge clk);
        rst_n = 1'b1;

        // No demand: one AR2 cycle then MAIN_G held
        run(12);
        chk("idle_hold", {5'd0, phase}, 8'd0);

        // Continuous side demand: full cycles, no walk
        side_req = 1'b1;
        run(30);
        chk("side_nowalk", walk_seen[7:0], 8'd0);
        side_req = 1'b0;
        run_until(0, 20, "back_main");
        run(6);

        // Pedestrian pulse in MAIN_G -> walk for exactly TW cycles
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        walk_seen = 0;
        run_until(3, 20, "ped_sideg");
        run(10);
        chk("walk_len", walk_seen[7:0], TW[7:0]);

        // Press during SIDE_G is ignored
        side_req = 1'b1;
        run_until(3, 20, "ign_sideg");
        side_req = 1'b0;
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        run(20);
        chk("ign_hold", {5'd0, phase}, 8'd0);

        // Press exactly on the AR1->SIDE_G edge counts as served
        side_req = 1'b1;
        run_until(2, 20, "edge_ar1");
        side_req = 1'b0;
        ped_req = 1'b1;
        walk_seen = 0;
        step();
        ped_req = 1'b0;
        run(10);
        chk("edge_walk", walk_seen[7:0], TW[7:0]);

        // Flash mid SIDE_G, blink, release through AR2
        side_req = 1'b1;
        run_until(3, 20, "fl_sideg");
        side_req = 1'b0;
        step();
        flash = 1'b1;
        step();
        chk("fl_enter", {5'd0, phase}, 8'd6);
        run(8);
        flash = 1'b0;
        step();
        chk("fl_ar2", {5'd0, phase}, 8'd5);
        step();
        chk("fl_main", {5'd0, phase}, 8'd0);

        // Random demand and flash bursts
        for (int i = 0; i < 400; i++) begin
            side_req = ($urandom % 6) == 0;
            ped_req  = ($urandom % 9) == 0;
            if (($urandom % 40) == 0) flash = ~flash;
            step();
        end
        flash = 1'b0;
        side_req = 1'b1;
        ped_req = 1'b0;

        // Reset mid SIDE_Y aborts straight to all-red
        run_until(4, 40, "rst_sidey");
        rst_n = 1'b0;
        #1;
        chk("mrst_main", {5'd0, main_light}, 8'h04);
        chk("mrst_side", {5'd0, side_light}, 8'h04);
        chk("mrst_walk", {7'd0, walk}, 8'd0);
        chk("mrst_phase", {5'd0, phase}, 8'd5);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        side_req = 1'b0;
        run(8);
        chk("mrst_main_g", {5'd0, phase}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
